mult_div: RTL and testbench
===========================

MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL have parameter DIVZERO_LO, default 32'hFFFFFFFF: the lo value reported on divide-by-zero.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  EX-stage request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port operand_1  input  32  multiplicand / dividend (rs value from ID).
REQ-007 SHALL have port operand_2  input  32  multiplier / divisor (rt value from ID).
REQ-008 SHALL have port flush  input  1  pipeline flush; cancels any operation in progress.
REQ-009 SHALL have port busy  output  1  stall request to the pipeline.
REQ-010 SHALL have port done  output  1  one-cycle pulse; hi/lo valid with it.
REQ-011 SHALL have port hi  output  32  high product word / remainder, registered.
REQ-012 SHALL have port lo  output  32  low product word / quotient, registered.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX and DONE.
REQ-014 IDLE with start=1 and flush=0 SHALL latch op and both operands and go to CALC with the 5-bit iteration counter at 0.
- Exception: DIV/DIVU with operand_2==0 SHALL go directly to DONE.
REQ-015 Signed ops SHALL first take absolute values of both operands and record the sign of the result (and of the remainder); unsigned ops SHALL use the operands unchanged.
REQ-016 CALC SHALL perform one radix-2 step per cycle:
- multiply: shift-add into a 64-bit accumulator;
- divide: restoring shift-subtract into a 64-bit remainder/quotient register.
REQ-017 CALC SHALL last exactly 32 cycles (counter 0..31) and then go to FIX.
REQ-018 FIX SHALL apply sign correction:
- MULT: negate the 64-bit product if the operand signs differ;
- DIV: negate the quotient if the signs differ, and negate the remainder if the dividend was negative.
- FIX SHALL write hi/lo and go to DONE.
REQ-019 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-020 Latency: start in cycle 0 SHALL give done=1 in cycle 34; divide-by-zero SHALL give done=1 in cycle 1.
REQ-021 busy SHALL be 1 in CALC and FIX, and combinationally 1 in IDLE when start=1 and flush=0; otherwise 0 (including in DONE).
REQ-022 start SHALL be ignored in CALC, FIX and DONE, with no queuing.
REQ-023 Divide-by-zero SHALL produce hi=operand_1 unmodified and lo=DIVZERO_LO, for both DIV and DIVU.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL produce lo=0x80000000 and hi=0 without error.
REQ-025 flush=1 in any state SHALL force IDLE at the next edge with no done pulse and hi/lo unchanged; flush has priority over start.
REQ-026 hi/lo SHALL change only at the FIX→DONE transition (or the IDLE→DONE divide-by-zero transition) and SHALL hold otherwise.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, counter=0, busy=0, done=0, hi=0 and lo=0, overriding flush and start.
REQ-028 rst asserted mid-operation SHALL abandon the operation with no done pulse, and the block SHALL accept a new start in the first cycle after rst deasserts.

Verification
REQ-029 MULT 0xFFFFFFFF x 0x00000002 -> done in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU on the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-030 DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100 / 7 -> lo=14, hi=2; busy high in cycles 0-33 and low in cycle 34.
REQ-031 DIVU 0x12345678 / 0 -> done in cycle 1, hi=0x12345678, lo=0xFFFFFFFF, busy high in cycle 0 only.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
REQ-033 flush in cycle 10 of a MULT -> state IDLE at cycle 11, no done pulse, hi/lo retain their prior values; a start in cycle 11 is accepted normally.
REQ-034 start held high for 40 cycles from cycle 0 -> exactly one done (cycle 34), and a second operation accepted in cycle 35; rst in cycle 5 of an operation -> no done, all outputs 0.

Source files
------------

// File: rtl/mult_div.sv
// -----------------------------------------------------------------------------
// mult_div : iterative 32x32 multiply / divide unit for the EX stage.
//   One radix-2 step per clock: shift-add for MULT/MULTU, restoring
//   shift-subtract for DIV/DIVU. Signed ops run on magnitudes and are
//   sign-corrected in a final FIX cycle. Divide-by-zero bypasses the loop.
//
// Ports
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset
//   start      : request a new operation (only honoured in IDLE)
//   op         : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_1  : multiplicand / dividend
//   operand_2  : multiplier / divisor
//   flush      : cancel any operation, return to IDLE
//   busy       : stall request to the pipeline
//   done       : one-cycle pulse, hi/lo valid with it
//   hi         : product high word / remainder (registered)
//   lo         : product low word / quotient (registered)
// -----------------------------------------------------------------------------
module mult_div #(
  parameter logic [31:0] DIVZERO_LO = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_is_div;
  logic        r_neg_res;   // product / quotient must be negated
  logic        r_neg_rem;   // remainder must be negated (dividend negative)
  logic [31:0] r_opnd;      // |operand_2|: multiplicand addend or divisor
  logic [63:0] r_acc;       // {hi, lo} working register
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // Operation decode and magnitude conversion of the incoming operands.
  logic        w_signed;
  logic        w_is_div;
  logic        w_div_zero;
  logic        w_accept;
  logic [31:0] w_abs_1;
  logic [31:0] w_abs_2;

  assign w_signed   = ~op[0];
  assign w_is_div   = op[1];
  assign w_div_zero = w_is_div && (operand_2 == 32'd0);
  assign w_accept   = (r_state == S_IDLE) && start && !flush;
  assign w_abs_1    = (w_signed && operand_1[31]) ? (32'd0 - operand_1) : operand_1;
  assign w_abs_2    = (w_signed && operand_2[31]) ? (32'd0 - operand_2) : operand_2;

  // Multiply step: multiplier sits in the low half and is consumed LSB-first;
  // the 33-bit sum keeps the carry, which shifts back into bit 63.
  logic [32:0] w_add;
  logic [63:0] w_mul_next;

  assign w_add      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_next = {w_add, r_acc[31:1]};

  // Divide step: the partial remainder can reach bit 63, so after the
  // shift it is 33 bits wide. When it fits, the difference is < divisor
  // and therefore fits back into 32 bits.
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [63:0] w_div_next;
  logic [63:0] w_step;

  assign w_rem_sh   = r_acc[63:31];
  assign w_ge       = (w_rem_sh >= {1'b0, r_opnd});
  assign w_diff     = w_rem_sh[31:0] - r_opnd;
  assign w_div_next = w_ge ? {w_diff, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};
  assign w_step     = r_is_div ? w_div_next : w_mul_next;

  // Sign correction applied in FIX. Magnitude quotient of 0x80000000/1
  // negates back to 0x80000000, so the overflow case needs no special path.
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;

  assign w_prod_fix = r_neg_res ? (64'd0 - r_acc) : r_acc;
  assign w_quo_fix  = r_neg_res ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
  assign w_rem_fix  = r_neg_rem ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
  assign w_fix_hi   = r_is_div ? w_rem_fix : w_prod_fix[63:32];
  assign w_fix_lo   = r_is_div ? w_quo_fix : w_prod_fix[31:0];

  // busy covers the request cycle itself so the pipeline stalls immediately.
  assign busy = (r_state == S_CALC) || (r_state == S_FIX) || w_accept;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 5'd0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_opnd    <= 32'd0;
      r_acc     <= 64'd0;
      r_done    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (w_div_zero) begin
              r_hi    <= operand_1;
              r_lo    <= DIVZERO_LO;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_is_div  <= w_is_div;
              r_opnd    <= w_abs_2;
              r_acc     <= {32'd0, w_abs_1};
              r_neg_res <= w_signed & (operand_1[31] ^ operand_2[31]);
              r_neg_rem <= w_signed & operand_1[31];
              r_cnt     <= 5'd0;
              r_state   <= S_CALC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_acc <= w_step;
          if (r_cnt == 5'd31) begin
            r_cnt   <= 5'd0;
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// -----------------------------------------------------------------------------
// tb_mult_div : self-checking bench for mult_div. Expected hi/lo and latency
// come from a plain-arithmetic reference model (64-bit integer multiply,
// truncating divide/remainder). Directed scenarios then random operations.
// -----------------------------------------------------------------------------
module tb_mult_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_hi;   // value hi/lo must hold between results
  logic [31:0] exp_lo;

  always #5 clk = ~clk;

  mult_div dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .operand_1 (opa),
    .operand_2 (opb),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: results from ordinary integer arithmetic.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l, output int lat);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (o[1] && b == 32'd0) begin
      h = a; l = 32'hFFFFFFFF; lat = 1;
    end else begin
      lat = 34;
      case (o)
        2'd0: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
        2'd1: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
        2'd2: begin sq = sa / sb; sr = sa % sb; h = sr[31:0]; l = sq[31:0]; end
        default: begin h = a % b; l = a / b; end
      endcase
    end
  endtask

  // Issue one operation in the current cycle and follow it to its done pulse.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mh, ml;
    int          lat;
    int          dcyc;
    model(o, a, b, mh, ml, lat);
    dcyc  = -1;
    op    = o; opa = a; opb = b;
    start = 1'b1; flush = 1'b0;
    #1;
    chk("busy_c0", busy, 1);
    step();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done === 1'b1) begin
        dcyc = c;
        break;
      end
      chk("hold_hi", hi, exp_hi);
      chk("hold_lo", lo, exp_lo);
      chk("busy_run", busy, 1);
      step();
    end
    chk("latency", dcyc, lat);
    if (dcyc > 0) begin
      chk("res_hi", hi, mh);
      chk("res_lo", lo, ml);
      chk("busy_done", busy, 0);
      exp_hi = mh;
      exp_lo = ml;
      step();
      chk("done_pulse", done, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mh, ml;
    int          lat, ndone, first, dcyc;

    // Reset state
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; opa = 32'd0; opb = 32'd0;
    step(); step();
    rst = 1'b0;
    #1;
    exp_hi = 32'd0; exp_lo = 32'd0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);

    // Directed arithmetic cases
    run_op(2'd0, 32'hFFFFFFFF, 32'h00000002);
    run_op(2'd1, 32'hFFFFFFFF, 32'h00000002);
    run_op(2'd2, 32'hFFFFFFF9, 32'h00000002);
    run_op(2'd3, 32'd100, 32'd7);
    run_op(2'd3, 32'h12345678, 32'd0);
    run_op(2'd2, 32'h87654321, 32'd0);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF);
    run_op(2'd0, 32'h80000000, 32'h80000000);
    run_op(2'd2, 32'd5, 32'hFFFFFFFD);

    // Flush in cycle 10 of a MULT, new start in cycle 11
    op = 2'd0; opa = 32'h00001234; opb = 32'hFFFF0001; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_hi", hi, exp_hi);
    chk("flush_lo", lo, exp_lo);
    run_op(2'd1, 32'hDEADBEEF, 32'h00C0FFEE);

    // flush beats start in IDLE
    op = 2'd1; opa = 32'd3; opb = 32'd4; start = 1'b1; flush = 1'b1;
    #1;
    chk("flushprio_busy_c0", busy, 0);
    step();
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flushprio_busy_c1", busy, 0);
    chk("flushprio_done", done, 0);

    // start held 40 cycles: one done at 34, second op accepted in cycle 35
    model(2'd3, 32'd1000, 32'd33, mh, ml, lat);
    op = 2'd3; opa = 32'd1000; opb = 32'd33; start = 1'b1;
    ndone = 0; first = -1;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = c;
        chk("held_hi", hi, mh);
        chk("held_lo", lo, ml);
      end
      if (c == 34) chk("held_busy_done", busy, 0);
      if (c == 35) begin
        opa = 32'hFFFFFFF0; opb = 32'd3; op = 2'd2;
        #1;
        chk("held_busy_c35", busy, 1);
      end
      if (c == 36) chk("held_busy_c36", busy, 1);
      step();
    end
    start = 1'b0;
    chk("held_ndone", ndone, 1);
    chk("held_first", first, 34);
    model(2'd2, 32'hFFFFFFF0, 32'd3, mh, ml, lat);
    dcyc = -1;
    for (int c = 40; c < 80; c++) begin
      if (done === 1'b1) begin
        dcyc = c;
        break;
      end
      step();
    end
    chk("held_second_cycle", dcyc, 69);
    chk("held_second_hi", hi, mh);
    chk("held_second_lo", lo, ml);
    exp_hi = mh; exp_lo = ml;
    step();
    chk("held_second_pulse", done, 0);

    // rst in cycle 5 of an operation
    op = 2'd0; opa = 32'h00000777; opb = 32'h00000999; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    exp_hi = 32'd0; exp_lo = 32'd0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    run_op(2'd3, 32'hFFFFFFFF, 32'h00010000);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h80000000;
        2: rb = 32'($urandom_range(1, 15));
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      run_op(ro, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
